llc_mem_bridge: RTL and testbench

Memory-side bridge directly downstream of the LLC core. It accepts LLC memory requests (line fills and write-backs) and serializes each into a header flit plus data flits toward the memory tile. It collects memory response beats into a full line and returns it to the LLC core on the memory-response channel. It allows at most one outstanding read; writes are posted.

---
 rtl/llc_mem_bridge.sv | 195 +++++++++++++++++++
 tb/tb_llc_mem_bridge.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_mem_bridge.sv
// llc_mem_bridge
//   Memory-side bridge below the LLC core. Each LLC memory request becomes a
//   header flit, and a write-back also sends BEATS data flits, least
//   significant word first. Response beats are collected into a full line and
//   returned to the LLC core. At most one read may be outstanding. Writes are
//   posted and get no response.
//
// Ports
//   clk, rst            clock (rising edge); asynchronous active-low reset
//   llc_mem_req_*       request from LLC core (valid/ready, hwrite, hsize,
//                       hprot, addr, line)
//   mem_out_*           flit channel to memory (valid/ready, data, last)
//   mem_in_*            response beat channel (valid/ready, data)
//   llc_mem_rsp_*       assembled line back to LLC core (valid/ready, line)
//   rsp_err             sticky: a beat arrived while no read was outstanding
//   perf_rd_cnt/wr_cnt  saturating header counters
//   state_dbg           request FSM state
//
// Configuration
//   LLC_MEM_BRIDGE_PERF_EN  when defined, perf_rd_cnt/perf_wr_cnt count read and
//                           write header handshakes and saturate at 16'hFFFF.
//                           When undefined, both ports are tied to zero.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A source keeps valid and its payload stable until that edge.
// Valid never depends combinationally on the ready of the same channel.
// The header layout {hwrite, hsize, hprot, addr} needs WORD_BITS >= ADDR_BITS+6.
module llc_mem_bridge #(
    parameter int ADDR_BITS = 32,
    parameter int LINE_BITS = 128,
    parameter int WORD_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 llc_mem_req_valid,
    output logic                 llc_mem_req_ready,
    input  logic                 llc_mem_req_hwrite,
    input  logic [2:0]           llc_mem_req_hsize,
    input  logic [1:0]           llc_mem_req_hprot,
    input  logic [ADDR_BITS-1:0] llc_mem_req_addr,
    input  logic [LINE_BITS-1:0] llc_mem_req_line,
    output logic                 mem_out_valid,
    input  logic                 mem_out_ready,
    output logic [WORD_BITS-1:0] mem_out_data,
    output logic                 mem_out_last,
    input  logic                 mem_in_valid,
    output logic                 mem_in_ready,
    input  logic [WORD_BITS-1:0] mem_in_data,
    output logic                 llc_mem_rsp_valid,
    input  logic                 llc_mem_rsp_ready,
    output logic [LINE_BITS-1:0] llc_mem_rsp_line,
    output logic                 rsp_err,
    output logic [15:0]          perf_rd_cnt,
    output logic [15:0]          perf_wr_cnt,
    output logic [1:0]           state_dbg
);

    localparam int BEATS = LINE_BITS / WORD_BITS;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

    state_t state, state_nxt;

    logic                             req_hwrite;
    logic [2:0]                       req_hsize;
    logic [1:0]                       req_hprot;
    logic [ADDR_BITS-1:0]             req_addr;
    logic [BEATS-1:0][WORD_BITS-1:0]  req_words;
    logic [BEATS-1:0][WORD_BITS-1:0]  rsp_words;
    logic [CNT_W-1:0]                 beat_cnt;
    logic [CNT_W-1:0]                 rsp_cnt;
    logic                             rd_outstanding;
    logic [WORD_BITS-1:0]             header;

    logic req_fire, hdr_fire, data_fire, beat_last, rsp_last, in_fire, rsp_fire;

    assign llc_mem_req_ready = (state == IDLE) && !rd_outstanding;
    assign req_fire          = llc_mem_req_valid && llc_mem_req_ready;
    assign hdr_fire          = (state == HEADER) && mem_out_ready;
    assign data_fire         = (state == DATA) && mem_out_ready;
    assign beat_last         = (beat_cnt == CNT_W'(BEATS - 1));
    assign rsp_last          = (rsp_cnt == CNT_W'(BEATS - 1));
    assign mem_in_ready      = !llc_mem_rsp_valid;
    assign in_fire           = mem_in_valid && mem_in_ready;
    assign rsp_fire          = llc_mem_rsp_valid && llc_mem_rsp_ready;
    assign llc_mem_rsp_line  = rsp_words;
    assign state_dbg         = state;

    always_comb begin
        header                     = '0;
        header[ADDR_BITS-1:0]      = req_addr;
        header[ADDR_BITS +: 2]     = req_hprot;
        header[ADDR_BITS+2 +: 3]   = req_hsize;
        header[ADDR_BITS+5]        = req_hwrite;
    end

    // Request FSM: next state and flit outputs, all decoded from registered state.
    always_comb begin
        state_nxt     = state;
        mem_out_valid = 1'b0;
        mem_out_data  = '0;
        mem_out_last  = 1'b0;
        case (state)
            IDLE: begin
                if (req_fire) state_nxt = HEADER;
            end
            HEADER: begin
                mem_out_valid = 1'b1;
                mem_out_data  = header;
                mem_out_last  = !req_hwrite;
                if (mem_out_ready) state_nxt = req_hwrite ? DATA : IDLE;
            end
            DATA: begin
                mem_out_valid = 1'b1;
                mem_out_data  = req_words[beat_cnt];
                mem_out_last  = beat_last;
                if (mem_out_ready && beat_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            req_hwrite <= 1'b0;
            req_hsize  <= '0;
            req_hprot  <= '0;
            req_addr   <= '0;
            req_words  <= '0;
            beat_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (req_fire) begin
                req_hwrite <= llc_mem_req_hwrite;
                req_hsize  <= llc_mem_req_hsize;
                req_hprot  <= llc_mem_req_hprot;
                req_addr   <= llc_mem_req_addr;
                req_words  <= llc_mem_req_line;
            end
            if (hdr_fire && req_hwrite) beat_cnt <= '0;
            else if (data_fire)         beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Response path runs independently of the request FSM; it only shares
    // rd_outstanding, which the read header sets and the line handshake clears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_outstanding    <= 1'b0;
            rsp_words         <= '0;
            rsp_cnt           <= '0;
            llc_mem_rsp_valid <= 1'b0;
            rsp_err           <= 1'b0;
        end else begin
            if (rsp_fire) begin
                llc_mem_rsp_valid <= 1'b0;
                rd_outstanding    <= 1'b0;
            end
            if (hdr_fire && !req_hwrite) rd_outstanding <= 1'b1;
            if (in_fire) begin
                if (rd_outstanding) begin
                    rsp_words[rsp_cnt] <= mem_in_data;
                    rsp_cnt            <= rsp_last ? '0 : rsp_cnt + 1'b1;
                    if (rsp_last) llc_mem_rsp_valid <= 1'b1;
                end else begin
                    // Stray beat: dropped without disturbing line assembly.
                    rsp_err <= 1'b1;
                end
            end
        end
    end

`ifdef LLC_MEM_BRIDGE_PERF_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (hdr_fire) begin
            if (!req_hwrite && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            if (req_hwrite && wr_cnt_q != 16'hFFFF)  wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end

    assign perf_rd_cnt = rd_cnt_q;
    assign perf_wr_cnt = wr_cnt_q;
`else
    assign perf_rd_cnt = '0;
    assign perf_wr_cnt = '0;
`endif

endmodule

// File: tb/tb_llc_mem_bridge.sv
// Testbench for llc_mem_bridge (default parameters: 32-bit addr, 128-bit line,
// 64-bit words, two beats per line). Inputs change 1 ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_llc_mem_bridge;

  localparam int AW    = 32;
  localparam int LW    = 128;
  localparam int WW    = 64;
  localparam int BEATS = LW / WW;
  localparam int LIM   = 200;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          llc_mem_req_valid, llc_mem_req_ready, llc_mem_req_hwrite;
  logic [2:0]    llc_mem_req_hsize;
  logic [1:0]    llc_mem_req_hprot;
  logic [AW-1:0] llc_mem_req_addr;
  logic [LW-1:0] llc_mem_req_line;
  logic          mem_out_valid, mem_out_ready, mem_out_last;
  logic [WW-1:0] mem_out_data;
  logic          mem_in_valid, mem_in_ready;
  logic [WW-1:0] mem_in_data;
  logic          llc_mem_rsp_valid, llc_mem_rsp_ready;
  logic [LW-1:0] llc_mem_rsp_line;
  logic          rsp_err;
  logic [15:0]   perf_rd_cnt, perf_wr_cnt;
  logic [1:0]    state_dbg;

  llc_mem_bridge #(.ADDR_BITS(AW), .LINE_BITS(LW), .WORD_BITS(WW)) dut (
    .clk(clk), .rst(rst),
    .llc_mem_req_valid(llc_mem_req_valid), .llc_mem_req_ready(llc_mem_req_ready),
    .llc_mem_req_hwrite(llc_mem_req_hwrite), .llc_mem_req_hsize(llc_mem_req_hsize),
    .llc_mem_req_hprot(llc_mem_req_hprot), .llc_mem_req_addr(llc_mem_req_addr),
    .llc_mem_req_line(llc_mem_req_line),
    .mem_out_valid(mem_out_valid), .mem_out_ready(mem_out_ready),
    .mem_out_data(mem_out_data), .mem_out_last(mem_out_last),
    .mem_in_valid(mem_in_valid), .mem_in_ready(mem_in_ready), .mem_in_data(mem_in_data),
    .llc_mem_rsp_valid(llc_mem_rsp_valid), .llc_mem_rsp_ready(llc_mem_rsp_ready),
    .llc_mem_rsp_line(llc_mem_rsp_line), .rsp_err(rsp_err),
    .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [WW:0]   exp_q[$];      // {last, data} of every expected flit, in order
  logic [LW-1:0] rsp_exp_q[$];  // expected assembled lines
  int   exp_rd = 0, exp_wr = 0;
  logic exp_err = 1'b0;
  int   out_mode = 0, rsp_mode = 0;  // 0 = ready high, 1 = low, 2 = random
  bit   out_stall_prev = 0, rsp_hold_prev = 0;
  logic [WW:0]   out_prev;
  logic [LW-1:0] rsp_prev;
  bit   saw_last, saw_req, saw_in, saw_rsp;

  typedef struct {
    logic          hwrite;
    logic [2:0]    hsize;
    logic [1:0]    hprot;
    logic [AW-1:0] addr;
    logic [LW-1:0] line;
    logic [WW-1:0] b0, b1;
    logic [WW-1:0] exp_hdr;
    logic          exp_hdr_last;
    logic [LW-1:0] exp_rsp;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Falling-edge monitor: ordering, hold-under-backpressure, and which
  // handshakes will complete at the next rising edge.
  task automatic mon();
    saw_last = 0; saw_req = 0; saw_in = 0; saw_rsp = 0;
    if (rst !== 1'b1) begin
      out_stall_prev = 0;
      rsp_hold_prev  = 0;
      return;
    end
    if (out_stall_prev) begin
      check("out_hold_valid", mem_out_valid, 1'b1);
      check("out_hold_flit", {mem_out_last, mem_out_data}, out_prev);
    end
    out_stall_prev = mem_out_valid && !mem_out_ready;
    out_prev       = {mem_out_last, mem_out_data};
    if (mem_out_valid && mem_out_ready) begin
      check("flit_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("flit", {mem_out_last, mem_out_data}, exp_q.pop_front());
      saw_last = mem_out_last;
    end
    if (rsp_hold_prev) begin
      check("rsp_hold_valid", llc_mem_rsp_valid, 1'b1);
      check("rsp_hold_line", llc_mem_rsp_line, rsp_prev);
    end
    rsp_hold_prev = llc_mem_rsp_valid && !llc_mem_rsp_ready;
    rsp_prev      = llc_mem_rsp_line;
    if (llc_mem_rsp_valid && llc_mem_rsp_ready) begin
      check("rsp_expected", rsp_exp_q.size() != 0, 1'b1);
      if (rsp_exp_q.size() != 0) check("rsp_line", llc_mem_rsp_line, rsp_exp_q.pop_front());
      saw_rsp = 1;
    end
    saw_in  = mem_in_valid && mem_in_ready;
    saw_req = llc_mem_req_valid && llc_mem_req_ready;
  endtask

  task automatic drive_bp();
    case (out_mode)
      0:       mem_out_ready = 1'b1;
      1:       mem_out_ready = 1'b0;
      default: mem_out_ready = ($urandom_range(0, 3) != 0);
    endcase
    case (rsp_mode)
      0:       llc_mem_rsp_ready = 1'b1;
      1:       llc_mem_rsp_ready = 1'b0;
      default: llc_mem_rsp_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    drive_bp();
  endtask

  // ---------------- reference model ----------------
  // Header = hwrite*2^37 + hsize*2^34 + hprot*2^32 + addr; writes add the
  // line words low-first with last on the final one.
  task automatic model_push(input logic w, input logic [2:0] sz, input logic [1:0] pr,
                            input logic [AW-1:0] a, input logic [LW-1:0] ln);
    logic [WW-1:0] hdr;
    hdr = (64'(w) << 37) + (64'(sz) << 34) + (64'(pr) << 32) + 64'(a);
    exp_q.push_back({!w, hdr});
    if (w) for (int i = 0; i < BEATS; i++) exp_q.push_back({i == BEATS - 1, ln[i*WW +: WW]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic w, input logic [2:0] sz, input logic [1:0] pr,
                          input logic [AW-1:0] a, input logic [LW-1:0] ln);
    int n = 0;
    llc_mem_req_valid = 1'b1; llc_mem_req_hwrite = w; llc_mem_req_hsize = sz;
    llc_mem_req_hprot = pr;   llc_mem_req_addr = a;   llc_mem_req_line = ln;
    do begin step(); n++; end while (!saw_req && n < LIM);
    check("req_accept_wait", saw_req, 1'b1);
    llc_mem_req_valid = 1'b0;
    if (w) exp_wr++; else exp_rd++;
  endtask

  task automatic wait_last();
    int n = 0;
    do begin step(); n++; end while (!saw_last && n < LIM);
    check("last_flit_wait", saw_last, 1'b1);
  endtask

  task automatic wait_rsp();
    int n = 0;
    do begin step(); n++; end while (!saw_rsp && n < LIM);
    check("rsp_wait", saw_rsp, 1'b1);
  endtask

  task automatic send_beat(input logic [WW-1:0] d);
    int n = 0;
    mem_in_valid = 1'b1; mem_in_data = d;
    do begin step(); n++; end while (!saw_in && n < LIM);
    check("beat_accept_wait", saw_in, 1'b1);
    mem_in_valid = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] sz, input logic [1:0] pr, input logic [AW-1:0] a,
                         input logic [WW-1:0] b0, input logic [WW-1:0] b1, input bit gaps);
    model_push(1'b0, sz, pr, a, '0);
    rsp_exp_q.push_back({b1, b0});
    send_req(1'b0, sz, pr, a, '0);
    wait_last();
    if (gaps) repeat ($urandom_range(0, 3)) step();
    send_beat(b0);
    if (gaps) repeat ($urandom_range(0, 3)) step();
    send_beat(b1);
    wait_rsp();
  endtask

  task automatic do_write(input logic [2:0] sz, input logic [1:0] pr, input logic [AW-1:0] a,
                          input logic [LW-1:0] ln);
    model_push(1'b1, sz, pr, a, ln);
    send_req(1'b1, sz, pr, a, ln);
    wait_last();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_req_ready"}, llc_mem_req_ready, 1'b1);
    check({tag, "_out_valid"}, mem_out_valid, 1'b0);
    check({tag, "_out_last"},  mem_out_last, 1'b0);
    check({tag, "_out_data"},  mem_out_data, '0);
    check({tag, "_in_ready"},  mem_in_ready, 1'b1);
    check({tag, "_rsp_valid"}, llc_mem_rsp_valid, 1'b0);
    check({tag, "_rsp_line"},  llc_mem_rsp_line, '0);
    check({tag, "_rsp_err"},   rsp_err, 1'b0);
    check({tag, "_perf_rd"},   perf_rd_cnt, '0);
    check({tag, "_perf_wr"},   perf_wr_cnt, '0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic          w;
    logic [2:0]    sz;
    logic [1:0]    pr;
    logic [AW-1:0] a;
    logic [LW-1:0] ln;
    logic [WW-1:0] b0, b1;

    vecs[0] = '{1'b0, 3'b011, 2'b11, 32'h0000_1240, '0, 64'hA, 64'hB,
                64'h0000_000F_0000_1240, 1'b1, {64'hB, 64'hA}};
    vecs[1] = '{1'b1, 3'b011, 2'b11, 32'h0000_2000, {64'h2222, 64'h1111}, '0, '0,
                64'h0000_002F_0000_2000, 1'b0, '0};
    vecs[2] = '{1'b1, 3'b011, 2'b01, 32'h8000_0080,
                {64'hCAFE_F00D_0000_0002, 64'h1234_5678_9ABC_DEF0}, '0, '0,
                64'h0000_002D_8000_0080, 1'b0, '0};
    vecs[3] = '{1'b0, 3'b101, 2'b10, 32'hFFFF_FFC0, '0,
                64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                64'h0000_0016_FFFF_FFC0, 1'b1, {64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}};

    llc_mem_req_valid = 0; llc_mem_req_hwrite = 0; llc_mem_req_hsize = 0;
    llc_mem_req_hprot = 0; llc_mem_req_addr = 0; llc_mem_req_line = 0;
    mem_out_ready = 1; mem_in_valid = 0; mem_in_data = 0; llc_mem_rsp_ready = 1;

    repeat (3) @(posedge clk);
    #1;
    reset_checks("por");
    rst = 1'b1;
    drive_bp();
    step();

    // Table-driven basic reads and writes.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({vecs[i].exp_hdr_last, vecs[i].exp_hdr});
      if (vecs[i].hwrite) begin
        exp_q.push_back({1'b0, vecs[i].line[WW-1:0]});
        exp_q.push_back({1'b1, vecs[i].line[LW-1:WW]});
      end
      send_req(vecs[i].hwrite, vecs[i].hsize, vecs[i].hprot, vecs[i].addr, vecs[i].line);
      check("hdr_valid_next_cycle", mem_out_valid, 1'b1);
      wait_last();
      if (vecs[i].hwrite) begin
        check("wr_ready_after_last", llc_mem_req_ready, 1'b1);
      end else begin
        check("rd_blocks_req", llc_mem_req_ready, 1'b0);
        rsp_exp_q.push_back(vecs[i].exp_rsp);
        send_beat(vecs[i].b0);
        send_beat(vecs[i].b1);
        check("rsp_valid_after_beat2", llc_mem_rsp_valid, 1'b1);
        check("rsp_line_after_beat2", llc_mem_rsp_line, vecs[i].exp_rsp);
        wait_rsp();
        check("rd_ready_after_rsp", llc_mem_req_ready, 1'b1);
      end
    end

    // Flit back-pressure: stall beat 0 of a write for 5 cycles.
    model_push(1'b1, 3'b011, 2'b00, 32'h0000_5000, {64'h4444, 64'h3333});
    send_req(1'b1, 3'b011, 2'b00, 32'h0000_5000, {64'h4444, 64'h3333});
    step();
    check("bp_hdr_sent", exp_q.size(), 2);
    out_mode = 1; drive_bp();
    repeat (5) step();
    check("bp_beat0_valid", mem_out_valid, 1'b1);
    check("bp_beat0_data", mem_out_data, 64'h3333);
    check("bp_beat0_last", mem_out_last, 1'b0);
    out_mode = 0; drive_bp();
    wait_last();
    check("bp_ready_after_last", llc_mem_req_ready, 1'b1);

    // Response back-pressure: line and mem_in_ready held for 3 cycles.
    rsp_mode = 1; drive_bp();
    model_push(1'b0, 3'b011, 2'b01, 32'h0000_6000, '0);
    rsp_exp_q.push_back({64'h66, 64'h55});
    send_req(1'b0, 3'b011, 2'b01, 32'h0000_6000, '0);
    wait_last();
    send_beat(64'h55);
    send_beat(64'h66);
    check("rsp_bp_valid", llc_mem_rsp_valid, 1'b1);
    check("rsp_bp_in_ready", mem_in_ready, 1'b0);
    repeat (3) step();
    check("rsp_bp_in_ready_held", mem_in_ready, 1'b0);
    check("rsp_bp_line_held", llc_mem_rsp_line, {64'h66, 64'h55});
    rsp_mode = 0; drive_bp();
    wait_rsp();

    // Second read while one is outstanding.
    model_push(1'b0, 3'b011, 2'b11, 32'h0000_7000, '0);
    send_req(1'b0, 3'b011, 2'b11, 32'h0000_7000, '0);
    wait_last();
    llc_mem_req_valid = 1'b1; llc_mem_req_hwrite = 1'b0; llc_mem_req_hsize = 3'b010;
    llc_mem_req_hprot = 2'b00; llc_mem_req_addr = 32'h0000_7100; llc_mem_req_line = '0;
    model_push(1'b0, 3'b010, 2'b00, 32'h0000_7100, '0);
    repeat (3) begin
      step();
      check("rd2_blocked", llc_mem_req_ready, 1'b0);
    end
    rsp_exp_q.push_back({64'h72, 64'h71});
    send_beat(64'h71);
    send_beat(64'h72);
    wait_rsp();
    check("rd2_ready_after_rsp", llc_mem_req_ready, 1'b1);
    step();
    check("rd2_accepted", saw_req, 1'b1);
    llc_mem_req_valid = 1'b0;
    exp_rd++;
    check("rd2_hdr_valid", mem_out_valid, 1'b1);
    wait_last();
    rsp_exp_q.push_back({64'h74, 64'h73});
    send_beat(64'h73);
    send_beat(64'h74);
    wait_rsp();

    // Reset during write DATA beat 1.
    model_push(1'b1, 3'b011, 2'b11, 32'h0000_8000, {64'h8888, 64'h7777});
    send_req(1'b1, 3'b011, 2'b11, 32'h0000_8000, {64'h8888, 64'h7777});
    step();
    step();
    check("rst_one_beat_left", exp_q.size(), 1);
    rst = 1'b0;
    #1;
    reset_checks("mid");
    exp_q.delete();
    exp_rd = 0; exp_wr = 0; exp_err = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    do_read(3'b011, 2'b11, 32'h0000_9000, 64'h91, 64'h92, 0);

    // Stray beat with nothing outstanding.
    send_beat(64'hDEAD);
    exp_err = 1'b1;
    check("spur_err", rsp_err, exp_err);
    check("spur_no_rsp", llc_mem_rsp_valid, 1'b0);
    check("spur_in_ready", mem_in_ready, 1'b1);
    do_read(3'b011, 2'b11, 32'h0000_A000, 64'hA1, 64'hA2, 0);
    do_read(3'b001, 2'b01, 32'h0000_A100, 64'hA3, 64'hA4, 1);
    do_write(3'b011, 2'b10, 32'h0000_B000, {64'hB2, 64'hB1});
    do_write(3'b011, 2'b10, 32'h0000_B010, {64'hB4, 64'hB3});
    check("spur_err_sticky", rsp_err, exp_err);
`ifdef LLC_MEM_BRIDGE_PERF_EN
    check("perf_rd_3", perf_rd_cnt, 16'd3);
    check("perf_wr_2", perf_wr_cnt, 16'd2);
`else
    check("perf_rd_off", perf_rd_cnt, '0);
    check("perf_wr_off", perf_wr_cnt, '0);
`endif

    // Randomized mix against the model.
    for (int t = 0; t < 40; t++) begin
      out_mode = (t % 3 == 0) ? 0 : 2;
      rsp_mode = (t % 2 == 0) ? 0 : 2;
      drive_bp();
      w  = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 7));
      pr = 2'($urandom_range(0, 3));
      a  = $urandom & 32'hFFFF_FFF0;
      ln = {$urandom, $urandom, $urandom, $urandom};
      b0 = {$urandom, $urandom};
      b1 = {$urandom, $urandom};
      if (w) do_write(sz, pr, a, ln);
      else   do_read(sz, pr, a, b0, b1, 1);
    end

    out_mode = 0; rsp_mode = 0; drive_bp();
    repeat (3) step();
    check("end_flits_drained", exp_q.size(), 0);
    check("end_rsps_drained", rsp_exp_q.size(), 0);
    check("end_rsp_err", rsp_err, exp_err);
`ifdef LLC_MEM_BRIDGE_PERF_EN
    check("end_perf_rd", perf_rd_cnt, 16'(exp_rd));
    check("end_perf_wr", perf_wr_cnt, 16'(exp_wr));
`else
    check("end_perf_rd", perf_rd_cnt, '0);
    check("end_perf_wr", perf_wr_cnt, '0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
